pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised inter-stage pipeline register that replaces the fixed-field, busy-wait-stalled stage registers.
- Carries a control bundle and a data bundle between CPU pipeline stages using a valid/ready handshake.
- Optional 2-entry skid buffer gives a registered upstream ready, plus synchronous flush (bubble insertion) and a stall-cycle performance counter.
- Sits between any two stages (IF/ID … MEM/WB); control bits are forced to zero on bubbles so downstream write enables stay inactive.

Parameters:
- CTRL_W, 8, width of control bundle (REG_WRITE, MEM_READ, MEM_TO_REG, …); zeroed whenever the output is invalid.
- DATA_W, 96, width of data bundle (ALU result, read data, PC, rd address, …).
- SKID, 1, 1 = 2-entry skid buffer with registered IN_READY; 0 = single register with combinational IN_READY.
- CNT_W, 16, width of the stall counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous flush: discard all held entries and any beat presented this cycle.
- IN_VALID  input  1  upstream beat valid.
- IN_READY  output  1  stage can accept a beat this cycle.
- IN_CTRL  input  CTRL_W  upstream control bundle.
- IN_DATA  input  DATA_W  upstream data bundle.
- OUT_VALID  output  1  downstream beat valid.
- OUT_READY  input  1  downstream accepts the beat (replaces BUSY_WAIT; tie to !BUSY_WAIT).
- OUT_CTRL  output  CTRL_W  control of the head entry; 0 when OUT_VALID=0.
- OUT_DATA  output  DATA_W  data of the head entry.
- OCCUPANCY  output  2  number of held entries: 0, 1 or 2.
- STALL_CNT  output  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

Behaviour:
- Handshake:
  - Accept = IN_VALID & IN_READY & !FLUSH.
  - Fire = OUT_VALID & OUT_READY.
  - IN_CTRL/IN_DATA are sampled only on accept.
  - The downstream must not see OUT_CTRL/OUT_DATA change while OUT_VALID=1 and OUT_READY=0.
- Latency: an accepted beat appears on OUT_* at the next posedge (1 cycle). Order is strictly preserved; no beat is lost or duplicated.
- SKID=1 state machine (main register M, skid register S):
  - EMPTY: OCCUPANCY=0, OUT_VALID=0, IN_READY=1. Accept -> FULL1 with M<=in.
  - FULL1: OCCUPANCY=1, OUT_VALID=1, IN_READY=1.
    - Accept & fire -> FULL1, M<=in.
    - Accept & !fire -> FULL2, S<=in.
    - !accept & fire -> EMPTY.
    - Otherwise hold.
  - FULL2: OCCUPANCY=2, OUT_VALID=1, IN_READY=0 (driven from state only, no combinational path from OUT_READY). Fire -> FULL1, M<=S. Otherwise hold.
- SKID=0: only EMPTY/FULL1.
  - IN_READY = !OUT_VALID | OUT_READY (combinational).
  - Accept & fire in the same cycle loads the new beat. OCCUPANCY is never 2.
- Bubbles: OUT_CTRL = 0 whenever OUT_VALID=0. OUT_DATA holds its last value while invalid, except after reset/flush, when it is 0.
- FLUSH (1 cycle):
  - Next state EMPTY; M and S are invalidated and OUT_DATA is zeroed.
  - A beat presented in the flush cycle is dropped.
  - Fire in the flush cycle still counts as delivered downstream.
  - STALL_CNT is not affected.
- RESET:
  - Priority over FLUSH and the handshake.
  - Next cycle: state EMPTY, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0, OCCUPANCY=0, STALL_CNT=0.
  - IN_READY is forced 0 while RESET=1 and is 1 the cycle after reset deasserts.
  - Reset mid-transfer discards held entries.
- STALL_CNT: increments by 1 on each cycle with OUT_VALID=1 & OUT_READY=0, saturates at 2^CNT_W-1 (no wrap), and is cleared only by RESET.

Test Plan:
- Streaming: reset, OUT_READY=1, send IN_DATA 1,2,3,4 on consecutive cycles -> OUT_DATA 1,2,3,4 one cycle later each, OUT_VALID continuous, IN_READY stays 1, STALL_CNT=0.
- Backpressure / skid: SKID=1, send A=0x11, B=0x22 with OUT_READY=0 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=0x11 held. Raise OUT_READY -> 0x11 then 0x22. STALL_CNT equals the number of held cycles.
- Bubble: IN_CTRL=0xFF, IN_VALID=1 for one cycle only, OUT_READY=1 -> OUT_CTRL=0xFF for one cycle, then OUT_CTRL=0x00 with OUT_VALID=0.
- Flush in FULL2 with IN_VALID=1, IN_DATA=0x33 -> next cycle OCCUPANCY=0, OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0; 0x33 never appears.
- Reset priority: assert RESET and FLUSH together in FULL1 -> all outputs 0, STALL_CNT=0, IN_READY=0 during reset and 1 the cycle after.
- Saturation: CNT_W=4, hold OUT_VALID=1 with OUT_READY=0 for 20 cycles -> STALL_CNT stops at 15; SKID=0 build repeats the streaming test with identical output.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush (bubble insertion) and a saturating stall-cycle counter.
module pipe_skid_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W-1:0]  stall_cnt;
    logic              out_valid;
    logic              in_ready;
    logic              accept;
    logic              fire;

    assign out_valid = (state != EMPTY);
    assign accept    = IN_VALID && in_ready && !FLUSH;
    assign fire      = out_valid && OUT_READY;

    // With the skid buffer, ready depends only on state so it never sees OUT_READY.
    always_comb begin
        in_ready = 1'b0;
        if (RESET)
            in_ready = 1'b0;
        else if (SKID != 0)
            in_ready = (state != FULL2);
        else
            in_ready = !out_valid || OUT_READY;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= EMPTY;
            m_ctrl    <= '0;
            m_data    <= '0;
            s_ctrl    <= '0;
            s_data    <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !OUT_READY && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;

            if (FLUSH) begin
                state  <= EMPTY;
                m_ctrl <= '0;
                m_data <= '0;
                s_ctrl <= '0;
                s_data <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state  <= FULL1;
                            m_ctrl <= IN_CTRL;
                            m_data <= IN_DATA;
                        end
                    end
                    FULL1: begin
                        if (accept && fire) begin
                            m_ctrl <= IN_CTRL;
                            m_data <= IN_DATA;
                        end else if (accept) begin
                            state  <= FULL2;
                            s_ctrl <= IN_CTRL;
                            s_data <= IN_DATA;
                        end else if (fire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL2: begin
                        if (fire) begin
                            state  <= FULL1;
                            m_ctrl <= s_ctrl;
                            m_data <= s_data;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid;
    assign OUT_CTRL  = out_valid ? m_ctrl : '0;
    assign OUT_DATA  = m_data;
    assign OCCUPANCY = 2'(state);
    assign STALL_CNT = stall_cnt;

endmodule
